// File: rtl/if_fetch_unit.sv
//==============================================================================
// Module   : if_fetch_unit
// Function : Instruction fetch front end. Issues sequential fetches into a
//            2-entry {addr, inst} FIFO and presents the head instruction to
//            the IF/ID register. A redirect that arrives while a request is
//            still outstanding waits in DRAIN for that request's ack, then
//            throws the returned word away.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_flush,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_addr_out,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_fifo_addr [0:1];
    logic [31:0] r_fifo_inst [0:1];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;
    logic [31:0] w_target;

    // Request generation: REQ only asks while there is room; DRAIN keeps the
    // abandoned request alive until memory answers it.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        case (r_state)
            S_REQ:   w_req = (r_count < 2'd2);
            S_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
            end
            default: begin
                w_req  = 1'b0;
                w_addr = r_pc;
            end
        endcase
    end

    assign w_target = branch_target & ~32'h0000_0003;
    assign w_push   = (r_state == S_REQ) && w_req && imem_ack && !pc_src;
    assign w_pop    = !if_flush && (r_count != 2'd0) && !pc_src;
    assign w_valid  = (r_count != 2'd0);

    assign imem_req      = w_req;
    assign imem_addr     = w_addr;
    assign inst_valid    = w_valid;
    assign inst_out      = w_valid ? r_fifo_inst[r_rptr] : NOP_INST;
    assign inst_addr_out = w_valid ? r_fifo_addr[r_rptr] : 32'h0000_0000;
    assign fetch_busy    = (r_state == S_DRAIN);

    // Control state: FSM, pc, drain address and FIFO occupancy. A redirect
    // overrides every other event in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= 32'h0000_0000;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
        end else if (pc_src) begin
            r_pc    <= w_target;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_req && !imem_ack) begin
                        r_drain_addr <= w_addr;
                        r_state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 32'd4;
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                S_IDLE:  r_state <= S_REQ;
                S_REQ:   r_state <= S_REQ;
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage: pure datapath, only meaningful under r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= r_pc;
            r_fifo_inst[r_wptr] <= imem_rdata;
        end
    end

endmodule

`default_nettype wire
